// File: rtl/vc_arb_pkg.sv
// Shared constants and helpers for the virtual-channel output multiplexer.
// Optional round-robin arbitration is selected with the VC_ARB_RR_EN macro.
package vc_arb_pkg;

  localparam int unsigned MAX_VC = 8;

  localparam logic [63:0] DATA_RST = '0;
  localparam logic [63:0] CNT_RST  = '0;

  // Index width for n channels; never narrower than one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/vc_arb_mux_if.sv
// VC-head / destination bundle for vc_arb_mux.
// The master side is the multiplexer; the slave side is the FIFO and destination environment.
interface vc_arb_mux_if
  import vc_arb_pkg::*;
#(
  parameter int unsigned DATA_W = 6,
  parameter int unsigned NUM_VC = 2,
  parameter int unsigned CNT_W  = 8
);
  localparam int unsigned VC_W = clog2(NUM_VC);

  logic [NUM_VC*DATA_W-1:0] data_in;
  logic [NUM_VC-1:0]        valid_in;
  logic [NUM_VC-1:0]        pop;
  logic                     dst_ready;
  logic                     valid_out;
  logic [DATA_W-1:0]        data_out;
  logic [VC_W-1:0]          vc_out;
  logic [NUM_VC*CNT_W-1:0]  xfer_cnt;
  logic                     idle;

  modport master (
    input  data_in, valid_in, dst_ready,
    output pop, valid_out, data_out, vc_out, xfer_cnt, idle
  );

  modport slave (
    output data_in, valid_in, dst_ready,
    input  pop, valid_out, data_out, vc_out, xfer_cnt, idle
  );

endinterface

// File: rtl/vc_arb_sel.sv
// Combinational VC selector: one-hot grant, its index, and any-valid flag.
// With VC_ARB_RR_EN the search starts at ptr; otherwise the lowest valid index wins.
module vc_arb_sel
  import vc_arb_pkg::*;
#(
  parameter int unsigned NUM_VC = 2,
  parameter int unsigned VC_W   = 1
) (
  input  logic [NUM_VC-1:0] valid_in,
  input  logic [VC_W-1:0]   ptr,
  input  logic              enable,
  output logic [NUM_VC-1:0] grant,
  output logic [VC_W-1:0]   idx,
  output logic              any_valid
);

  logic found;

  assign any_valid = |valid_in;

`ifdef VC_ARB_RR_EN
  // Rotating search: first valid VC at or after ptr, wrapping modulo NUM_VC.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int unsigned off = 0; off < NUM_VC; off++) begin
      if (!found && valid_in[(32'(ptr) + off) % NUM_VC]) begin
        found = 1'b1;
        idx   = VC_W'((32'(ptr) + off) % NUM_VC);
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Fixed priority: VC0 highest.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_VC; i++) begin
      if (!found && valid_in[i]) begin
        found = 1'b1;
        idx   = VC_W'(i);
      end
    end
  end
`endif

  always_comb begin
    grant = '0;
    for (int unsigned i = 0; i < NUM_VC; i++) begin
      grant[i] = enable && found && (idx == VC_W'(i));
    end
  end

endmodule

// File: rtl/vc_arb_mux.sv
// N-channel VC output multiplexer: pops one FIFO head per load and registers it toward the destination.
// Define VC_ARB_RR_EN for round-robin arbitration; default is strict priority (VC0 highest).
module vc_arb_mux
  import vc_arb_pkg::*;
#(
  parameter int unsigned DATA_W = 6,
  parameter int unsigned NUM_VC = 2,
  parameter int unsigned CNT_W  = 8
) (
  input  logic          clk,
  input  logic          reset,
  vc_arb_mux_if.master  bus
);

  localparam int unsigned VC_W = clog2(NUM_VC);

  if (NUM_VC < 2 || NUM_VC > MAX_VC) begin : g_bad_num_vc
    $error("vc_arb_mux: NUM_VC out of range 2..8");
  end

  logic                 load_en;
  logic                 sel_en;
  logic                 any_valid;
  logic                 granted;
  logic [NUM_VC-1:0]    grant;
  logic [VC_W-1:0]      grant_idx;
  logic [VC_W-1:0]      ptr;
  logic [DATA_W-1:0]    data_sel;

  logic                 valid_q;
  logic [DATA_W-1:0]    data_q;
  logic [VC_W-1:0]      vc_q;
  logic [CNT_W-1:0]     cnt [NUM_VC];

  // Output register is free when empty or being drained; dst_ready is moot while empty.
  assign load_en = !valid_q || bus.dst_ready;
  assign sel_en  = load_en && !reset;
  assign granted = |grant;

  vc_arb_sel #(
    .NUM_VC (NUM_VC),
    .VC_W   (VC_W)
  ) u_sel (
    .valid_in  (bus.valid_in),
    .ptr       (ptr),
    .enable    (sel_en),
    .grant     (grant),
    .idx       (grant_idx),
    .any_valid (any_valid)
  );

  always_comb begin
    data_sel = '0;
    for (int unsigned i = 0; i < NUM_VC; i++) begin
      if (grant[i]) data_sel = bus.data_in[i*DATA_W +: DATA_W];
    end
  end

`ifdef VC_ARB_RR_EN
  // Pointer moves past the winner only on an actual grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (granted) begin
      ptr <= (grant_idx == VC_W'(NUM_VC - 1)) ? '0 : grant_idx + VC_W'(1);
    end
  end
`else
  assign ptr = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= DATA_W'(DATA_RST);
      vc_q    <= '0;
    end else if (load_en) begin
      if (granted) begin
        valid_q <= 1'b1;
        data_q  <= data_sel;
        vc_q    <= grant_idx;
      end else begin
        valid_q <= 1'b0;
        data_q  <= DATA_W'(DATA_RST);
        vc_q    <= '0;
      end
    end
  end

  // Per-VC pop counters, free-running modulo 2^CNT_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_VC; i++) cnt[i] <= CNT_W'(CNT_RST);
    end else begin
      for (int unsigned i = 0; i < NUM_VC; i++) begin
        if (grant[i]) cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  for (genvar i = 0; i < NUM_VC; i++) begin : g_cnt_out
    assign bus.xfer_cnt[i*CNT_W +: CNT_W] = cnt[i];
  end

  assign bus.pop       = grant;
  assign bus.valid_out = valid_q;
  assign bus.data_out  = data_q;
  assign bus.vc_out    = vc_q;
  assign bus.idle      = !any_valid && !valid_q;

endmodule

// File: tb/tb_vc_arb_mux.sv
// Directed bench for vc_arb_mux with 4 VCs and 4-bit counters.
// Expected arbitration order follows VC_ARB_RR_EN as compiled.
module tb_vc_arb_mux;

  localparam int unsigned DATA_W = 6;
  localparam int unsigned NUM_VC = 4;
  localparam int unsigned CNT_W  = 4;

`ifdef VC_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [DATA_W-1:0] heads [NUM_VC] = '{6'h15, 6'h2A, 6'h07, 6'h38};

  vc_arb_mux_if #(.DATA_W(DATA_W), .NUM_VC(NUM_VC), .CNT_W(CNT_W)) bus ();

  vc_arb_mux #(.DATA_W(DATA_W), .NUM_VC(NUM_VC), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [31:0] cnt_of(input int unsigned i);
    return 32'(bus.xfer_cnt[i*CNT_W +: CNT_W]);
  endfunction

  initial begin
    int unsigned exp_vc;

    reset         = 1'b1;
    bus.valid_in  = 4'b0011;
    bus.data_in   = {heads[3], heads[2], heads[1], heads[0]};
    bus.dst_ready = 1'b1;

    // Reset held two cycles with requests pending
    settle();
    check("rst_pop0", 32'(bus.pop), 32'h0);
    tick();
    check("rst_pop1", 32'(bus.pop), 32'h0);
    tick();
    check("rst_pop2", 32'(bus.pop), 32'h0);
    check("rst_valid", 32'(bus.valid_out), 32'h0);
    check("rst_data", 32'(bus.data_out), 32'h0);
    check("rst_vc", 32'(bus.vc_out), 32'h0);
    check("rst_cnt", 32'(bus.xfer_cnt), 32'h0);

    // First grant goes to VC0 in both arbitration modes
    reset = 1'b0;
    settle();
    check("first_pop", 32'(bus.pop), 32'h1);
    tick();
    check("first_data", 32'(bus.data_out), 32'h15);
    check("first_vc", 32'(bus.vc_out), 32'h0);
    check("first_valid", 32'(bus.valid_out), 32'h1);
    check("first_cnt0", cnt_of(0), 32'h1);

    // Backpressure: three stalled cycles hold everything
    bus.dst_ready = 1'b0;
    bus.valid_in  = 4'b0010;
    settle();
    check("stall_pop", 32'(bus.pop), 32'h0);
    repeat (3) begin
      tick();
      check("stall_data", 32'(bus.data_out), 32'h15);
      check("stall_valid", 32'(bus.valid_out), 32'h1);
      check("stall_pop", 32'(bus.pop), 32'h0);
    end
    check("stall_cnt1", cnt_of(1), 32'h0);
    bus.dst_ready = 1'b1;
    settle();
    check("resume_pop", 32'(bus.pop), 32'h2);
    tick();
    check("resume_data", 32'(bus.data_out), 32'h2A);
    check("resume_vc", 32'(bus.vc_out), 32'h1);
    check("resume_cnt1", cnt_of(1), 32'h1);

    // Drain to idle
    bus.valid_in = 4'b0000;
    settle();
    check("drain_idle", 32'(bus.idle), 32'h0);
    check("drain_pop", 32'(bus.pop), 32'h0);
    tick();
    check("idle_valid", 32'(bus.valid_out), 32'h0);
    check("idle_data", 32'(bus.data_out), 32'h0);
    check("idle", 32'(bus.idle), 32'h1);

    // dst_ready low is ignored while the output register is empty
    bus.dst_ready = 1'b0;
    bus.valid_in  = 4'b0100;
    settle();
    check("empty_pop", 32'(bus.pop), 32'h4);
    tick();
    check("empty_data", 32'(bus.data_out), 32'h07);
    check("empty_vc", 32'(bus.vc_out), 32'h2);
    check("empty_cnt2", cnt_of(2), 32'h1);
    check("full_stall_pop", 32'(bus.pop), 32'h0);

    // Reset while a word is held: word discarded, no pop during reset
    bus.valid_in = 4'b1111;
    reset        = 1'b1;
    settle();
    check("midrst_pop", 32'(bus.pop), 32'h0);
    tick();
    check("midrst_valid", 32'(bus.valid_out), 32'h0);
    check("midrst_data", 32'(bus.data_out), 32'h0);
    check("midrst_cnt", 32'(bus.xfer_cnt), 32'h0);

    // All VCs requesting: RR gives 0,1,2,3,0; priority always gives 0
    reset         = 1'b0;
    bus.dst_ready = 1'b1;
    settle();
    for (int unsigned i = 0; i < 5; i++) begin
      exp_vc = RR ? (i % 4) : 0;
      check("arb_pop", 32'(bus.pop), 32'h1 << exp_vc);
      tick();
      check("arb_vc", 32'(bus.vc_out), 32'(exp_vc));
      check("arb_data", 32'(bus.data_out), 32'(heads[exp_vc]));
    end
    check("arb_cnt", 32'(bus.xfer_cnt), RR ? 32'h1112 : 32'h0005);

    // Counter wrap: 16 pops of VC1 on a 4-bit counter
    reset = 1'b1;
    tick();
    reset        = 1'b0;
    bus.valid_in = 4'b0010;
    repeat (15) tick();
    check("wrap_cnt15", cnt_of(1), 32'hF);
    tick();
    check("wrap_cnt0", cnt_of(1), 32'h0);
    check("wrap_data", 32'(bus.data_out), 32'h2A);
    check("wrap_cnt_others", 32'(bus.xfer_cnt), 32'h0);

    bus.valid_in = 4'b0000;
    tick();
    check("end_valid", 32'(bus.valid_out), 32'h0);
    check("end_idle", 32'(bus.idle), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
